// File: rtl/tdc_fifo_reader.sv
// TDC FIFO reader: pops one 32-bit measurement word per frame and serialises it
// as a 6-byte frame (header, time1 hi/lo, calib_diff hi/lo, XOR checksum) to a
// byte transmitter. The transmitter busy flag throttles the frame. A guard
// cycle after every strobe lets the block see a late busy rise.
module tdc_fifo_reader (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_dout,
  output logic        fifo_rd_en,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_new_data,
  input  logic        pause,
  output logic [15:0] frame_count
);

  localparam logic [7:0] HEADER = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    SEND,
    GUARD
  } state_t;

  state_t      state;
  logic [31:0] hold_reg;
  logic [7:0]  chk;
  logic [2:0]  byte_idx;
  logic [7:0]  cur_byte;

  // Select the frame byte addressed by the byte index from the held word
  always_comb begin
    cur_byte = chk;
    case (byte_idx)
      3'd0:    cur_byte = HEADER;
      3'd1:    cur_byte = hold_reg[15:8];
      3'd2:    cur_byte = hold_reg[7:0];
      3'd3:    cur_byte = hold_reg[31:24];
      3'd4:    cur_byte = hold_reg[23:16];
      default: cur_byte = chk;
    endcase
  end

  // Frame sequencer: pop, latch, then send each byte with a guard cycle after it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      fifo_rd_en  <= 1'b0;
      tx_new_data <= 1'b0;
      tx_data     <= 8'h00;
      frame_count <= 16'h0000;
      byte_idx    <= 3'd0;
      hold_reg    <= 32'h0000_0000;
      chk         <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          tx_new_data <= 1'b0;
          if (!fifo_empty && !pause) begin
            fifo_rd_en <= 1'b1;
            state      <= READ;
          end else begin
            fifo_rd_en <= 1'b0;
          end
        end
        READ: begin
          fifo_rd_en <= 1'b0;
          state      <= LATCH;
        end
        LATCH: begin
          hold_reg <= fifo_dout;
          chk      <= fifo_dout[31:24] ^ fifo_dout[23:16] ^
                      fifo_dout[15:8]  ^ fifo_dout[7:0];
          byte_idx <= 3'd0;
          state    <= SEND;
        end
        SEND: begin
          if (!tx_busy) begin
            tx_data     <= cur_byte;
            tx_new_data <= 1'b1;
            state       <= GUARD;
          end else begin
            tx_new_data <= 1'b0;
          end
        end
        GUARD: begin
          tx_new_data <= 1'b0;
          if (byte_idx == 3'd5) begin
            frame_count <= frame_count + 16'd1;
            state       <= IDLE;
          end else begin
            byte_idx <= byte_idx + 3'd1;
            state    <= SEND;
          end
        end
        default: begin
          fifo_rd_en  <= 1'b0;
          tx_new_data <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_fifo_reader.sv
// Testbench for tdc_fifo_reader: a small FIFO model feeds words, a monitor
// records every transmitted byte and every pop, and directed scenarios compare
// the recorded frames against hand-computed byte sequences.
module tb_tdc_fifo_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fifo_empty;
  logic [31:0] fifo_dout = 32'h0;
  logic        fifo_rd_en;
  logic        tx_busy = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_new_data;
  logic        pause = 1'b0;
  logic [15:0] frame_count;

  logic [31:0] fifo_mem [0:15];
  logic [3:0]  wr_ptr = 4'd0;
  logic [3:0]  rd_ptr = 4'd0;

  logic [7:0]  rx_bytes [0:127];
  int          strobe_cyc [0:127];
  int          rd_cyc [0:31];
  int          rx_cnt = 0;
  int          rd_cnt = 0;
  int          cycle = 0;

  int          check_count = 0;
  int          error_count = 0;
  int          base;
  int          rd_base;

  tdc_fifo_reader dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_empty  (fifo_empty),
    .fifo_dout   (fifo_dout),
    .fifo_rd_en  (fifo_rd_en),
    .tx_busy     (tx_busy),
    .tx_data     (tx_data),
    .tx_new_data (tx_new_data),
    .pause       (pause),
    .frame_count (frame_count)
  );

  assign fifo_empty = (wr_ptr == rd_ptr);

  // 100 MHz-style clock, period 10
  always #5 clk = ~clk;

  // FIFO model and monitor: pops on rd_en, logs strobed bytes and pop cycles
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (tx_new_data) begin
      rx_bytes[rx_cnt]   <= tx_data;
      strobe_cyc[rx_cnt] <= cycle;
      rx_cnt             <= rx_cnt + 1;
    end
    if (fifo_rd_en) begin
      rd_cyc[rd_cnt] <= cycle;
      rd_cnt         <= rd_cnt + 1;
      if (wr_ptr != rd_ptr) begin
        fifo_dout <= fifo_mem[rd_ptr];
        rd_ptr    <= rd_ptr + 4'd1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] word);
    fifo_mem[wr_ptr] = word;
    wr_ptr = wr_ptr + 4'd1;
  endtask

  task automatic waitBytes(input string tag, input int n);
    int budget;
    budget = 0;
    while (rx_cnt < n && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    if (rx_cnt < n) checkOutput({tag, " timeout"}, rx_cnt, n);
  endtask

  task automatic checkFrame(input string tag, input int start, input logic [47:0] exp_bytes);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("%s byte%0d", tag, i), {24'h0, rx_bytes[start + i]},
                  {24'h0, exp_bytes[47 - 8*i -: 8]});
  endtask

  initial begin
    $display("[TB] starting tdc_fifo_reader bench");
    repeat (3) @(negedge clk);

    // Reset values while held in reset
    checkOutput("reset tx_data", {24'h0, tx_data}, 32'h0);
    checkOutput("reset tx_new_data", {31'h0, tx_new_data}, 32'h0);
    checkOutput("reset fifo_rd_en", {31'h0, fifo_rd_en}, 32'h0);
    checkOutput("reset frame_count", {16'h0, frame_count}, 32'h0);
    rst = 1'b1;

    // No pop while the FIFO is empty
    repeat (10) @(negedge clk);
    checkOutput("empty no pop", rd_cnt, 0);

    // Single word
    base = rx_cnt; rd_base = rd_cnt;
    applyStimulus(32'h0FA005D0);
    waitBytes("single", base + 6);
    repeat (3) @(negedge clk);
    checkFrame("single", base, 48'hA5_05_D0_0F_A0_7A);
    checkOutput("single pops", rd_cnt - rd_base, 1);
    checkOutput("single strobes", rx_cnt - base, 6);
    checkOutput("single frame_count", {16'h0, frame_count}, 32'd1);
    checkOutput("single latency", {31'h0, (strobe_cyc[base] - rd_cyc[rd_base]) >= 3}, 32'd1);
    checkOutput("tx_data held", {24'h0, tx_data}, 32'h7A);

    // Backpressure after the header strobe
    base = rx_cnt;
    applyStimulus(32'h0FA005D0);
    waitBytes("bp header", base + 1);
    tx_busy = 1'b1;
    repeat (100) @(negedge clk);
    checkOutput("bp stalled", rx_cnt - base, 1);
    checkOutput("bp data held", {24'h0, tx_data}, 32'hA5);
    tx_busy = 1'b0;
    waitBytes("bp", base + 6);
    repeat (3) @(negedge clk);
    checkFrame("bp", base, 48'hA5_05_D0_0F_A0_7A);
    checkOutput("bp strobes", rx_cnt - base, 6);
    checkOutput("bp frame_count", {16'h0, frame_count}, 32'd2);

    // Back-to-back frames
    base = rx_cnt; rd_base = rd_cnt;
    applyStimulus(32'h12345678);
    applyStimulus(32'hFFFF0000);
    waitBytes("b2b", base + 12);
    repeat (3) @(negedge clk);
    checkFrame("b2b f1", base, 48'hA5_56_78_12_34_08);
    checkFrame("b2b f2", base + 6, 48'hA5_00_00_FF_FF_00);
    checkOutput("b2b pops", rd_cnt - rd_base, 2);
    checkOutput("b2b pop after chk", {31'h0, rd_cyc[rd_base + 1] > strobe_cyc[base + 5]}, 32'd1);
    checkOutput("b2b frame_count", {16'h0, frame_count}, 32'd4);

    // Pause during byte 2: frame completes, then no pop until pause falls
    base = rx_cnt; rd_base = rd_cnt;
    applyStimulus(32'h12345678);
    applyStimulus(32'hFFFF0000);
    waitBytes("pause b2", base + 2);
    pause = 1'b1;
    waitBytes("pause f1", base + 6);
    repeat (20) @(negedge clk);
    checkFrame("pause f1", base, 48'hA5_56_78_12_34_08);
    checkOutput("pause no pop", rd_cnt - rd_base, 1);
    checkOutput("pause no bytes", rx_cnt - base, 6);
    pause = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("pause resume", rd_cnt - rd_base, 2);
    waitBytes("pause f2", base + 12);
    checkFrame("pause f2", base + 6, 48'hA5_00_00_FF_FF_00);

    // Asynchronous reset after byte 3
    repeat (3) @(negedge clk);
    base = rx_cnt; rd_base = rd_cnt;
    applyStimulus(32'h0FA005D0);
    waitBytes("rst", base + 4);
    #2 rst = 1'b0;
    #1;
    checkOutput("async tx_data", {24'h0, tx_data}, 32'h0);
    checkOutput("async frame_count", {16'h0, frame_count}, 32'h0);
    checkOutput("async tx_new_data", {31'h0, tx_new_data}, 32'h0);
    checkOutput("async fifo_rd_en", {31'h0, fifo_rd_en}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("rst no resume", rx_cnt - base, 4);
    checkOutput("rst no pop", rd_cnt - rd_base, 1);
    checkOutput("rst frame_count", {16'h0, frame_count}, 32'h0);

    // Frame counter wrap from a preloaded 16'hFFFF
    force dut.frame_count = 16'hFFFF;
    #1 release dut.frame_count;
    @(negedge clk);
    base = rx_cnt;
    applyStimulus(32'h0FA005D0);
    waitBytes("wrap", base + 6);
    repeat (2) @(negedge clk);
    checkFrame("wrap", base, 48'hA5_05_D0_0F_A0_7A);
    checkOutput("wrap frame_count", {16'h0, frame_count}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/tdc_fifo_reader.md
TDC_FIFO_READER -- requirements
Module: tdc_fifo_reader

Interface
REQ-001 HEADER, 8'hA5, sync byte sent first in every frame.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 fifo_empty  input  1  measurement FIFO empty flag.
REQ-005 fifo_dout  input  32  FIFO read data, {calib_diff[31:16], time1[15:0]}, valid the cycle after a cycle with fifo_rd_en high.
REQ-006 fifo_rd_en  output  1  FIFO pop strobe, registered.
REQ-007 tx_busy  input  1  byte transmitter busy.
REQ-008 tx_data  output  8  byte to transmitter, registered.
REQ-009 tx_new_data  output  1  one-cycle byte-valid strobe, registered.
REQ-010 pause  input  1  inhibit starting new frames.
REQ-011 frame_count  output  16  count of completed frames.

Function
REQ-012 The block SHALL pop one 32-bit word per frame and send a 6-byte frame: HEADER, time1[15:8], time1[7:0], calib_diff[15:8], calib_diff[7:0], CHK.
REQ-013 CHK SHALL equal the XOR of the four data bytes. HEADER SHALL be excluded from CHK.
REQ-014 The FSM states SHALL be IDLE, READ, LATCH, SEND and GUARD.
REQ-015 IDLE: when fifo_empty=0 and pause=0, the block SHALL drive fifo_rd_en=1 for the next cycle and go to READ. Otherwise it SHALL stay in IDLE with fifo_rd_en=0.
REQ-016 READ: fifo_rd_en SHALL be high during this state only, exactly one cycle per frame. The next state SHALL be LATCH.
REQ-017 LATCH: the block SHALL capture fifo_dout into a 32-bit holding register, compute CHK, clear the byte index to 0 and go to SEND.
REQ-018 SEND, tx_busy=0: the block SHALL drive tx_data to the byte selected by the index and pulse tx_new_data for exactly one cycle, then go to GUARD.
REQ-019 SEND, tx_busy=1: the block SHALL wait in SEND with tx_new_data=0.
REQ-020 GUARD: one cycle only, so a late tx_busy rise is seen. If index=5, the block SHALL increment frame_count and go to IDLE. Otherwise it SHALL increment the index and go to SEND.
REQ-021 tx_data SHALL hold its last value between strobes.
REQ-022 Latency: the first tx_new_data SHALL occur no earlier than 4 cycles after the IDLE cycle that sees fifo_empty=0, with tx_busy=0 throughout.
REQ-023 fifo_empty and pause SHALL be sampled in IDLE only. Once a frame has started it SHALL complete regardless of pause or fifo_empty.
REQ-024 A new pop SHALL NOT start before the GUARD cycle that follows the CHK strobe. There SHALL be no pop while any byte of the current frame is unsent.
REQ-025 frame_count SHALL wrap from 16'hFFFF to 16'h0000 with no other effect.
REQ-026 The block SHALL NOT pop when fifo_empty=1, including in the cycle of its deassertion edge if IDLE has not yet sampled it low.

Reset
REQ-027 On rst=0, regardless of clk, the block SHALL force: state to IDLE, fifo_rd_en=0, tx_new_data=0, tx_data=8'h00, frame_count=0, byte index=0, holding register=0.
REQ-028 Reset mid-frame SHALL abandon the frame. Unsent bytes SHALL NOT be sent after release, and the popped word is lost.
REQ-029 After rst deasserts, the first pop SHALL need a full IDLE evaluation cycle.

Verification
REQ-030 Single word: fifo_dout=32'h0FA005D0, tx_busy=0 -> exactly one fifo_rd_en pulse; tx bytes A5,05,D0,0F,A0,7A; frame_count=1.
REQ-031 Backpressure: tx_busy held high for 100 cycles after the header strobe -> no further tx_new_data until tx_busy falls. The remaining bytes follow unchanged, one strobe per byte.
REQ-032 Back-to-back: two words queued (12345678, then FFFF0000) -> the second fifo_rd_en comes after the first frame's CHK strobe; frames are A5,56,78,12,34,08 and A5,00,00,FF,FF,00.
REQ-033 Pause: pause asserted during byte 2 of a frame -> the frame completes with all 6 bytes, then there is no pop while pause=1 even if the FIFO is non-empty; popping resumes within 2 cycles of pause falling.
REQ-034 Reset mid-frame: rst=0 asynchronously after byte 3 -> outputs go to their reset values immediately with no clk edge needed; no remaining bytes are sent; frame_count=0.
REQ-035 Wrap: frame_count preloaded by 65535 frames, then one more frame -> frame_count=16'h0000.
